// File: rtl/regfile_write_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// regfile_write_scheduler_pkg
//   Shared sizing constants for the register-file write scheduler slice and a
//   small helper that sizes the starvation counter.
//   No ports (package).
// ----------------------------------------------------------------------------
package regfile_write_scheduler_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int REG_SIZE_DEF     = 2;
  localparam int REG_NUMS_DEF     = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  // Width needed to hold 0..limit; the counter saturates at the limit.
  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//   Per-register busy bits plus RAW/WAW hazard detection for the instruction
//   presented at decode.
//   Ports:
//     Clk, Reset_N           clock, synchronous active-low reset
//     set_valid, set_rd      instruction issuing this cycle marks set_rd busy
//     clr_valid, clr_rd      write being registered this cycle frees clr_rd
//     uses_rs1/rs1, uses_rs2/rs2, writes_rd/rd   decode operand description
//     hazard                 RAW or WAW hazard against the current busy bits
// ----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_write_scheduler_pkg::*;
#(
  parameter int REG_SIZE = REG_SIZE_DEF,
  parameter int REG_NUMS = REG_NUMS_DEF
) (
  input  logic                Clk,
  input  logic                Reset_N,
  input  logic                set_valid,
  input  logic [REG_SIZE-1:0] set_rd,
  input  logic                clr_valid,
  input  logic [REG_SIZE-1:0] clr_rd,
  input  logic                uses_rs1,
  input  logic [REG_SIZE-1:0] rs1,
  input  logic                uses_rs2,
  input  logic [REG_SIZE-1:0] rs2,
  input  logic                writes_rd,
  input  logic [REG_SIZE-1:0] rd,
  output logic                hazard
);

  logic [REG_NUMS-1:0] busy_r;
  logic [REG_NUMS-1:0] busy_next_s;
  logic                raw_s;
  logic                waw_s;

  // Next busy vector: clear first, then set, so a same-register collision leaves it busy.
  always_comb begin
    busy_next_s = busy_r;
    if (clr_valid) begin
      busy_next_s[clr_rd] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (set_valid) begin
      busy_next_s[set_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // Busy vector register.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      busy_r <= {REG_NUMS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Hazards only look at registered busy bits; there is no bypass from the write port.
  always_comb begin
    raw_s  = (uses_rs1 & busy_r[rs1]) | (uses_rs2 & busy_r[rs2]);
    waw_s  = writes_rd & busy_r[rd];
    hazard = raw_s | waw_s;
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_write_scheduler
//   Shares the single register-file write port between the fixed-latency
//   writeback (WB, always wins) and the multi-cycle unit (MC, req/ack), keeps
//   a busy scoreboard and stalls decode on RAW/WAW hazards or MC starvation.
//   Ports:
//     Clk, Reset_N                      clock, synchronous active-low reset
//     issue_*                           decode instruction description
//     issue_stall                       hold decode this cycle
//     wb_req/wb_rd/wb_data              writeback write request
//     mc_req/mc_rd/mc_data, mc_ack      multi-cycle write request and grant
//     rf_regWrite/rf_regW/rf_writeData  registered register-file write port
// ----------------------------------------------------------------------------
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int REG_SIZE     = REG_SIZE_DEF,
  parameter int REG_NUMS     = REG_NUMS_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 issue_valid,
  input  logic                 issue_uses_rs1,
  input  logic [REG_SIZE-1:0]  issue_rs1,
  input  logic                 issue_uses_rs2,
  input  logic [REG_SIZE-1:0]  issue_rs2,
  input  logic                 issue_writes_rd,
  input  logic [REG_SIZE-1:0]  issue_rd,
  output logic                 issue_stall,
  input  logic                 wb_req,
  input  logic [REG_SIZE-1:0]  wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 mc_req,
  input  logic [REG_SIZE-1:0]  mc_rd,
  input  logic [WORD_SIZE-1:0] mc_data,
  output logic                 mc_ack,
  output logic                 rf_regWrite,
  output logic [REG_SIZE-1:0]  rf_regW,
  output logic [WORD_SIZE-1:0] rf_writeData
);

  localparam int               CNT_W      = starve_cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic                 mc_ack_s;
  logic                 wr_valid_s;
  logic [REG_SIZE-1:0]  wr_rd_s;
  logic [WORD_SIZE-1:0] wr_data_s;
  logic                 hazard_s;
  logic                 starve_s;
  logic                 issue_stall_s;
  logic                 issue_fire_s;
  logic [CNT_W-1:0]     starve_cnt_r;

  // Fixed-priority arbiter: WB is never delayed, MC only takes idle slots.
  always_comb begin
    mc_ack_s   = mc_req & ~wb_req & Reset_N;
    wr_valid_s = wb_req | mc_ack_s;
    if (wb_req) begin
      wr_rd_s   = wb_rd;
      wr_data_s = wb_data;
    end else begin
      wr_rd_s   = mc_rd;
      wr_data_s = mc_data;
    end
  end

  // Decode stall: hazards or forced bubble, only while an instruction is presented.
  always_comb begin
    starve_s      = (starve_cnt_r >= STARVE_MAX);
    issue_stall_s = issue_valid & (hazard_s | starve_s);
    issue_fire_s  = issue_valid & ~issue_stall_s & issue_writes_rd;
  end

  assign mc_ack      = mc_ack_s;
  assign issue_stall = issue_stall_s;

  // Write port: one-cycle latency; address/data hold when no one writes.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      rf_regWrite  <= 1'b0;
      rf_regW      <= {REG_SIZE{1'b0}};
      rf_writeData <= {WORD_SIZE{1'b0}};
    end else if (wr_valid_s) begin
      rf_regWrite  <= 1'b1;
      rf_regW      <= wr_rd_s;
      rf_writeData <= wr_data_s;
    end else begin
      rf_regWrite  <= 1'b0;
    end
  end

  // Starvation counter: counts consecutive cycles MC is blocked by WB, saturating.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (mc_req & wb_req) begin
      if (starve_cnt_r < STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  regfile_scoreboard #(
    .REG_SIZE (REG_SIZE),
    .REG_NUMS (REG_NUMS)
  ) u_scoreboard (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .set_valid (issue_fire_s),
    .set_rd    (issue_rd),
    .clr_valid (wr_valid_s),
    .clr_rd    (wr_rd_s),
    .uses_rs1  (issue_uses_rs1),
    .rs1       (issue_rs1),
    .uses_rs2  (issue_uses_rs2),
    .rs2       (issue_rs2),
    .writes_rd (issue_writes_rd),
    .rd        (issue_rd),
    .hazard    (hazard_s)
  );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_regfile_write_scheduler
//   Directed scenarios with literal expectations, then randomized traffic,
//   all checked every cycle against a behavioural model of the scheduler.
// ----------------------------------------------------------------------------
module tb_regfile_write_scheduler;

  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        issue_valid, issue_uses_rs1, issue_uses_rs2, issue_writes_rd;
  logic [1:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_stall;
  logic        wb_req;
  logic [1:0]  wb_rd;
  logic [15:0] wb_data;
  logic        mc_req;
  logic [1:0]  mc_rd;
  logic [15:0] mc_data;
  logic        mc_ack;
  logic        rf_regWrite;
  logic [1:0]  rf_regW;
  logic [15:0] rf_writeData;

  int checks = 0;
  int errors = 0;

  regfile_write_scheduler dut (
    .Clk             (Clk),
    .Reset_N         (Reset_N),
    .issue_valid     (issue_valid),
    .issue_uses_rs1  (issue_uses_rs1),
    .issue_rs1       (issue_rs1),
    .issue_uses_rs2  (issue_uses_rs2),
    .issue_rs2       (issue_rs2),
    .issue_writes_rd (issue_writes_rd),
    .issue_rd        (issue_rd),
    .issue_stall     (issue_stall),
    .wb_req          (wb_req),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .mc_req          (mc_req),
    .mc_rd           (mc_rd),
    .mc_data         (mc_data),
    .mc_ack          (mc_ack),
    .rf_regWrite     (rf_regWrite),
    .rf_regW         (rf_regW),
    .rf_writeData    (rf_writeData)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic u1, input logic [1:0] r1,
                           input logic u2, input logic [1:0] r2,
                           input logic w, input logic [1:0] rd);
    issue_valid     = v;
    issue_uses_rs1  = u1;
    issue_rs1       = r1;
    issue_uses_rs2  = u2;
    issue_rs2       = r2;
    issue_writes_rd = w;
    issue_rd        = rd;
  endtask

  // ---------------- behavioural model ----------------
  // State as seen after the most recent posedge.
  bit        m_busy [4];
  int        m_wait;          // consecutive cycles MC has been blocked by WB
  bit        m_we;
  bit [1:0]  m_w;
  bit [15:0] m_d;

  initial begin
    bit e_ack, e_stall, hz;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0; m_we = 1'b0; m_w = 2'd0; m_d = 16'd0;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      e_ack = mc_req && !wb_req && Reset_N;
      hz = (issue_uses_rs1 && m_busy[issue_rs1]) || (issue_uses_rs2 && m_busy[issue_rs2]) ||
           (issue_writes_rd && m_busy[issue_rd]) || (m_wait >= LIMIT);
      e_stall = issue_valid && hz;
      chk("model_stall", {31'd0, issue_stall}, {31'd0, e_stall});
      chk("model_ack", {31'd0, mc_ack}, {31'd0, e_ack});
      chk("model_we", {31'd0, rf_regWrite}, {31'd0, m_we});
      chk("model_regW", {30'd0, rf_regW}, {30'd0, m_w});
      chk("model_data", {16'd0, rf_writeData}, {16'd0, m_d});
      // advance the model across the coming posedge
      if (!Reset_N) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_wait = 0; m_we = 1'b0; m_w = 2'd0; m_d = 16'd0;
      end else begin
        if (wb_req) begin
          m_we = 1'b1; m_w = wb_rd; m_d = wb_data;
        end else if (e_ack) begin
          m_we = 1'b1; m_w = mc_rd; m_d = mc_data;
        end else begin
          m_we = 1'b0;
        end
        if (wb_req || e_ack) m_busy[m_w] = 1'b0;
        if (issue_valid && !e_stall && issue_writes_rd) m_busy[issue_rd] = 1'b1;
        if (mc_req && wb_req) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        else m_wait = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit prev_ack;
    Reset_N = 1'b0;
    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    wb_req = 1'b1; wb_rd = 2'd1; wb_data = 16'hFFFF;
    mc_req = 1'b1; mc_rd = 2'd2; mc_data = 16'hEEEE;

    // 1. reset held two cycles with both requesters active
    tick(); tick();
    @(negedge Clk);
    chk("rst_we", {31'd0, rf_regWrite}, 32'd0);
    chk("rst_regW", {30'd0, rf_regW}, 32'd0);
    chk("rst_data", {16'd0, rf_writeData}, 32'd0);
    chk("rst_ack", {31'd0, mc_ack}, 32'd0);

    // 2. RAW stall released by a WB write
    tick();
    Reset_N = 1'b1; wb_req = 1'b0; mc_req = 1'b0;
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2);
    @(negedge Clk); chk("t2_issue_rd2", {31'd0, issue_stall}, 32'd0);
    tick();
    set_issue(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0);
    wb_req = 1'b1; wb_rd = 2'd2; wb_data = 16'h1234;
    @(negedge Clk); chk("t2_raw_stall", {31'd0, issue_stall}, 32'd1);
    tick();
    wb_req = 1'b0;
    @(negedge Clk);
    chk("t2_we", {31'd0, rf_regWrite}, 32'd1);
    chk("t2_regW", {30'd0, rf_regW}, 32'd2);
    chk("t2_data", {16'd0, rf_writeData}, 32'h1234);
    chk("t2_stall_drop", {31'd0, issue_stall}, 32'd0);

    // 3. WB beats MC, MC granted once WB drops
    tick();
    set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    wb_req = 1'b1; wb_rd = 2'd1; wb_data = 16'hAAAA;
    mc_req = 1'b1; mc_rd = 2'd3; mc_data = 16'h5555;
    @(negedge Clk); chk("t3_ack_blocked", {31'd0, mc_ack}, 32'd0);
    tick();
    wb_req = 1'b0;
    @(negedge Clk);
    chk("t3_ack", {31'd0, mc_ack}, 32'd1);
    chk("t3_wb_regW", {30'd0, rf_regW}, 32'd1);
    chk("t3_wb_data", {16'd0, rf_writeData}, 32'hAAAA);
    tick();
    mc_req = 1'b0;
    @(negedge Clk);
    chk("t3_mc_we", {31'd0, rf_regWrite}, 32'd1);
    chk("t3_mc_regW", {30'd0, rf_regW}, 32'd3);
    chk("t3_mc_data", {16'd0, rf_writeData}, 32'h5555);
    chk("t3_ack_pulse", {31'd0, mc_ack}, 32'd0);

    // 4. starvation bubble from the 5th blocked cycle
    tick();
    set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    wb_req = 1'b1; wb_rd = 2'd0; wb_data = 16'h0101;
    mc_req = 1'b1; mc_rd = 2'd0; mc_data = 16'h0BEE;
    for (int i = 1; i <= 5; i++) begin
      @(negedge Clk);
      chk($sformatf("t4_starve_c%0d", i), {31'd0, issue_stall}, (i >= 5) ? 32'd1 : 32'd0);
      if (i < 5) tick();
    end
    tick();
    wb_req = 1'b0;
    @(negedge Clk);
    chk("t4_ack", {31'd0, mc_ack}, 32'd1);
    chk("t4_stall_in_ack", {31'd0, issue_stall}, 32'd1);
    tick();
    mc_req = 1'b0;
    @(negedge Clk); chk("t4_stall_clear", {31'd0, issue_stall}, 32'd0);

    // 5. WAW stall, then same-cycle clear of r0 and set of r3
    tick(); set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    @(negedge Clk); chk("t5_set_r1", {31'd0, issue_stall}, 32'd0);
    tick(); set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0);
    @(negedge Clk); chk("t5_set_r0", {31'd0, issue_stall}, 32'd0);
    tick(); set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1);
    @(negedge Clk); chk("t5_waw", {31'd0, issue_stall}, 32'd1);
    tick(); set_issue(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3);
    wb_req = 1'b1; wb_rd = 2'd0; wb_data = 16'h0F0F;
    @(negedge Clk); chk("t5_set_r3", {31'd0, issue_stall}, 32'd0);
    tick(); set_issue(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    wb_req = 1'b0;
    @(negedge Clk); chk("t5_r0_free", {31'd0, issue_stall}, 32'd0);
    tick(); set_issue(1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0);
    @(negedge Clk); chk("t5_r3_busy", {31'd0, issue_stall}, 32'd1);

    // 6. reset while MC pending and r3 busy
    tick(); set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    Reset_N = 1'b0; wb_req = 1'b1; wb_rd = 2'd1; wb_data = 16'h7777;
    mc_req = 1'b1; mc_rd = 2'd2; mc_data = 16'hC0DE;
    @(negedge Clk); chk("t6_ack_in_rst", {31'd0, mc_ack}, 32'd0);
    tick(); Reset_N = 1'b1; wb_req = 1'b0;
    set_issue(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge Clk);
    chk("t6_busy_cleared", {31'd0, issue_stall}, 32'd0);
    chk("t6_ack_after", {31'd0, mc_ack}, 32'd1);
    chk("t6_we_after_rst", {31'd0, rf_regWrite}, 32'd0);
    tick(); mc_req = 1'b0; set_issue(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(negedge Clk);
    chk("t6_mc_regW", {30'd0, rf_regW}, 32'd2);
    chk("t6_mc_data", {16'd0, rf_writeData}, 32'hC0DE);

    // randomized traffic; MC keeps its request stable until granted
    for (int i = 0; i < 3000; i++) begin
      tick();
      prev_ack = mc_req && !wb_req && Reset_N;
      Reset_N = ($urandom_range(0, 49) != 0);
      if (prev_ack || !mc_req) begin
        mc_req  = ($urandom_range(0, 2) == 0);
        mc_rd   = 2'($urandom_range(0, 3));
        mc_data = 16'($urandom);
      end
      wb_req  = ($urandom_range(0, 4) < 2);
      wb_rd   = 2'($urandom_range(0, 3));
      wb_data = 16'($urandom);
      set_issue(($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom),
                1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
    end
    tick();
    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
